// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl
//   Turns per-frame line centroid results into a saturated signed steering
//   command (3-stage PD pipeline) and a servo PWM. A lost-line FSM holds the
//   last command for a while, then commits to full lock toward the side the
//   line was last seen.
//
//   Optional feature macro: LINE_STEER_DERIV_EN
//     defined     -> PD control (derivative term on err - prev_err)
//     not defined -> P only; prev_err and the KD multiplier are not built
//
// Ports
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   centroid_x   frame centroid, sampled when line_valid=1
//   line_valid   one-cycle result strobe
//   line_lost    qualifies line_valid: 1 = no line found
//   steer        signed steering command, +/-STEER_MAX
//   steer_valid  one-cycle pulse, 3 cycles after line_valid
//   state        IDLE=0, TRACK=1, HOLD=2, SEARCH=3
//   pwm_out      servo PWM, registered
module line_steer_ctrl #(
    parameter int IMG_W       = 640,
    parameter int KP          = 4,
    parameter int KD          = 2,
    parameter int FRAC        = 2,
    parameter int STEER_MAX   = 250,
    parameter int LOST_FRAMES = 8,
    parameter int PWM_PERIOD  = 1000,
    parameter int PWM_CENTER  = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(IMG_W)-1:0]   centroid_x,
    input  logic                       line_valid,
    input  logic                       line_lost,
    output logic signed [15:0]         steer,
    output logic                       steer_valid,
    output logic [1:0]                 state,
    output logic                       pwm_out
);
    localparam int X_W   = $clog2(IMG_W);
    localparam int LC_W  = $clog2(LOST_FRAMES + 1);
    localparam int CNT_W = $clog2(PWM_PERIOD);

    localparam logic signed [X_W:0]  SETPT     = (X_W+1)'(IMG_W / 2);
    localparam logic signed [15:0]   KP_S      = 16'(KP);
    localparam logic signed [16:0]   SAT_POS   = 17'(STEER_MAX);
    localparam logic signed [16:0]   SAT_NEG   = -17'(STEER_MAX);
    localparam logic signed [15:0]   STEER_POS = 16'(STEER_MAX);
    localparam logic signed [15:0]   STEER_NEG = -16'(STEER_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2, SEARCH = 2'd3} state_t;

    state_t            state_q, state_nx;
    logic [LC_W-1:0]   lost_cnt, lost_nx;
    logic              last_neg;            // sign of the last non-lost err

    assign state = state_q;

    // ---------------- Stage 1: error + state machine ----------------
    logic signed [X_W:0] err;
    assign err = $signed({1'b0, centroid_x}) - SETPT;

    always_comb begin
        state_nx = state_q;
        lost_nx  = lost_cnt;
        if (line_valid) begin
            if (line_lost) begin
                lost_nx = (lost_cnt == LC_W'(LOST_FRAMES)) ? lost_cnt : lost_cnt + 1'b1;
                unique case (state_q)
                    IDLE:   state_nx = IDLE;
                    TRACK,
                    HOLD:   state_nx = (lost_nx == LC_W'(LOST_FRAMES)) ? SEARCH : HOLD;
                    SEARCH: state_nx = SEARCH;
                endcase
            end else begin
                lost_nx  = '0;
                state_nx = TRACK;
            end
        end
    end

    // Each sample carries the state it resolved to; TRACK <=> non-lost sample.
    logic                s1_vld, s1_neg;
    logic signed [X_W:0] s1_err;
    state_t              s1_mode;
`ifdef LINE_STEER_DERIV_EN
    logic                s1_dz;             // force d=0 on entry into TRACK
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lost_cnt <= '0;
            last_neg <= 1'b0;
            s1_vld   <= 1'b0;
            s1_err   <= '0;
            s1_mode  <= IDLE;
            s1_neg   <= 1'b0;
`ifdef LINE_STEER_DERIV_EN
            s1_dz    <= 1'b0;
`endif
        end else begin
            s1_vld <= line_valid;
            if (line_valid) begin
                state_q  <= state_nx;
                lost_cnt <= lost_nx;
                s1_err   <= err;
                s1_mode  <= state_nx;
                s1_neg   <= line_lost ? last_neg : err[X_W];
                if (!line_lost) last_neg <= err[X_W];
`ifdef LINE_STEER_DERIV_EN
                s1_dz    <= !line_lost && (state_q != TRACK);
`endif
            end
        end
    end

    // ---------------- Stage 2: P and D products ----------------
    logic signed [15:0] err16, p_nx;
    assign err16 = {{(15-X_W){s1_err[X_W]}}, s1_err};
    assign p_nx  = KP_S * err16;

    logic               s2_vld, s2_neg;
    logic signed [15:0] s2_p;
    state_t             s2_mode;

`ifdef LINE_STEER_DERIV_EN
    localparam logic signed [15:0] KD_S = 16'(KD);
    logic signed [15:0] prev_err, d_nx, s2_d;
    assign d_nx = s1_dz ? '0 : KD_S * (err16 - prev_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_err <= '0;
            s2_d     <= '0;
        end else if (s1_vld) begin
            s2_d <= d_nx;
            if (s1_mode == TRACK) prev_err <= err16;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_p    <= '0;
            s2_mode <= IDLE;
            s2_neg  <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_p    <= p_nx;
                s2_mode <= s1_mode;
                s2_neg  <= s1_neg;
            end
        end
    end

    // ---------------- Stage 3: shift, clamp, state select ----------------
    logic signed [16:0] sum, u, u_sat;
`ifdef LINE_STEER_DERIV_EN
    assign sum = {s2_p[15], s2_p} + {s2_d[15], s2_d};
`else
    assign sum = {s2_p[15], s2_p};
`endif
    assign u     = sum >>> FRAC;
    assign u_sat = (u > SAT_POS) ? SAT_POS : (u < SAT_NEG) ? SAT_NEG : u;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steer       <= '0;
            steer_valid <= 1'b0;
        end else begin
            steer_valid <= s2_vld;
            if (s2_vld) begin
                unique case (s2_mode)
                    IDLE:   steer <= '0;
                    TRACK:  steer <= 16'(u_sat);
                    HOLD:   steer <= steer;     // last TRACK value
                    SEARCH: steer <= s2_neg ? STEER_NEG : STEER_POS;
                endcase
            end
        end
    end

    // ---------------- PWM ----------------
    // Duty only changes at the wrap so each period is a whole, glitch-free pulse.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   duty_lat, duty_nx;
    assign duty_nx = (CNT_W+1)'(PWM_CENTER) + (CNT_W+1)'(steer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            duty_lat <= (CNT_W+1)'(PWM_CENTER);
            pwm_out  <= 1'b0;
        end else begin
            if (cnt == CNT_W'(PWM_PERIOD - 1)) begin
                cnt      <= '0;
                duty_lat <= duty_nx;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pwm_out <= ({1'b0, cnt} < duty_lat);
        end
    end
endmodule
